sound_dma_channel: RTL and testbench
====================================

// Module: sound_dma_channel
// PURPOSE
// - Single 8-bit DMA channel (8237-channel subset) that services the Sound Blaster DSP's DMA requester.
// - Answers dma_req with memory-to-device reads (playback) or device-to-memory writes (record).
// - Drives an Avalon-style byte memory master; CPU programs it through an 8-byte I/O window.
// - Sits between sound.v's dma_soundblaster_* port and the system memory arbiter.
// PARAMETERS
// - none
// PORTS
// clk                in   1   system clock; the single clock for the block
// rst                in   1   synchronous, active-high reset
// io_address         in   3   register select
// io_read            in   1   register read strobe (1 cycle)
// io_readdata        out  8   register read data, combinational from io_address
// io_write           in   1   register write strobe (1 cycle)
// io_writedata       in   8   register write data
// dma_req            in   1   transfer request from the device
// dma_ack            out  1   1-cycle pulse: byte transferred
// dma_terminal       out  1   high together with dma_ack on the last byte of a block
// dma_readdata       out  8   memory byte to the device; valid while dma_ack=1
// dma_writedata      in   8   device byte to memory; sampled in state WR
// mem_address        out 24   {page, current address}
// mem_read           out  1   memory read request; held until mem_waitrequest=0
// mem_write          out  1   memory write request; held until mem_waitrequest=0
// mem_writedata      out  8   write data
// mem_waitrequest    in   1   slave stall
// mem_readdatavalid  in   1   read data valid
// mem_readdata       in   8   read data
// BEHAVIOUR
// - Registers (io_address): 0 addr[7:0], 1 addr[15:8], 2 page[7:0], 3 count[7:0], 4 count[15:8],
//   5 mode {bit0 autoinit, bit1 decrement, bit2 dir 1=device->memory}, 6 mask (bit0), 7 status (read only).
// - Writing 0/1 updates the base address and the current address. Writing 3/4 updates the base count and the current count.
// - Reading 0/1/3/4 returns the current value. Reading 5/6 returns the register; unused bits read 0.
// - Status = {5'b0, mask, dma_req, tc}. tc clears on an io_read of address 7; a same-cycle tc set wins.
// - Reset: all registers 0 except mask=1. State=IDLE. All outputs 0.
// - A block is count+1 bytes. Address steps +1 (or -1 if decrement) in 16 bits and wraps 0xFFFF<->0x0000; page never changes.
// - FSM:
//   - IDLE: if dma_req && !mask, latch mem_address; go to RD (dir=0) or WR (dir=1).
//   - RD: mem_read=1. When !mem_waitrequest, go to RDW.
//   - RDW: when mem_readdatavalid, latch mem_readdata into dma_readdata and go to ACK.
//   - WR: mem_write=1, mem_writedata=dma_writedata. When !mem_waitrequest, go to ACK.
//   - ACK: dma_ack=1 for one cycle; dma_terminal=1 iff current count==0. Update address/count. Go to HOLD.
//   - HOLD: one idle cycle so the requester can drop dma_req; then IDLE.
// - Update in ACK:
//   - Not terminal: count-1, address +/-1.
//   - Terminal: tc<=1. If autoinit, current<=base for address and count. Otherwise mask<=1 and current is left at final+step.
// - Latency, zero-wait memory:
//   - Read: req sampled at cycle t; mem_read at t+1; ack at t+2 + read latency.
//   - Write: ack at t+2.
// - An io write during a transfer takes effect immediately on the registers. The in-flight byte still uses its latched address.
// - Setting mask mid-transfer does not abort the current byte; it only blocks the next IDLE sample.
// - dma_readdata holds its last value outside ACK. dma_ack and dma_terminal are registered.
// - rst asserted mid-transfer: return to IDLE next cycle; mem_read/mem_write drop immediately (synchronous); registers reset.
// TESTING
// - Playback, 3-byte block:
//   - Setup: addr=0x1000, page=0x02, count=2, mode=0, mask=0, dma_req held.
//   - Required: reads at 0x021000, 0x021001, 0x021002. Three dma_ack pulses, terminal on the 3rd. Then mask=1 and status=0x05.
// - Autoinit decrement:
//   - Setup: addr=0x0001, count=1, mode=3.
//   - Required: reads at 0x0001 then 0x0000, terminal on the 2nd. Current reloads to addr=0x0001, count=1. Mask stays 0 and a 3rd request reads 0x0001.
// - Wrap:
//   - Setup: addr=0xFFFF, page=0x05, count=1.
//   - Required: reads at 0x05FFFF then 0x050000; page stays 0x05.
// - Record:
//   - Setup: mode=4, dma_writedata=0xA5, mem_waitrequest high 3 cycles.
//   - Required: mem_write held 4 cycles with data 0xA5; single ack; no ack while stalled.
// - Masked / holdoff:
//   - Stimulus: dma_req with mask=1.
//   - Required: no memory cycle. Then clear mask and drop req in the ACK cycle: exactly one byte transferred.
// - Reset mid-read:
//   - Stimulus: rst pulsed while in RDW.
//   - Required: next cycle mem_read=0, dma_ack=0, mask=1, all registers 0; no ack is ever produced.

Source files
------------

// File: rtl/sound_dma_channel.sv
// Single 8-bit DMA channel (8237 subset) serving the Sound Blaster DSP requester.
// Playback reads memory to the device, record writes device bytes to memory.
module sound_dma_channel (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  io_address,
  input  logic        io_read,
  output logic [7:0]  io_readdata,
  input  logic        io_write,
  input  logic [7:0]  io_writedata,
  input  logic        dma_req,
  output logic        dma_ack,
  output logic        dma_terminal,
  output logic [7:0]  dma_readdata,
  input  logic [7:0]  dma_writedata,
  output logic [23:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_writedata,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [7:0]  mem_readdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_WR   = 3'd3,
    S_ACK  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_base_addr, r_cur_addr;
  logic [15:0] r_base_cnt,  r_cur_cnt;
  logic [7:0]  r_page;
  logic [2:0]  r_mode;
  logic        r_mask, r_tc;
  logic [23:0] r_mem_address;
  logic        r_mem_read, r_mem_write;
  logic        r_dma_ack, r_dma_terminal;
  logic [7:0]  r_dma_readdata;
  logic [15:0] w_step;

  assign w_step        = r_mode[1] ? 16'hFFFF : 16'h0001;
  assign mem_address   = r_mem_address;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  // Device data is passed straight through while the write is pending.
  assign mem_writedata = (r_state == S_WR) ? dma_writedata : 8'h00;
  assign dma_ack       = r_dma_ack;
  assign dma_terminal  = r_dma_terminal;
  assign dma_readdata  = r_dma_readdata;

  always_comb begin
    io_readdata = 8'h00;
    case (io_address)
      3'd0: io_readdata = r_cur_addr[7:0];
      3'd1: io_readdata = r_cur_addr[15:8];
      3'd2: io_readdata = r_page;
      3'd3: io_readdata = r_cur_cnt[7:0];
      3'd4: io_readdata = r_cur_cnt[15:8];
      3'd5: io_readdata = {5'b0, r_mode};
      3'd6: io_readdata = {7'b0, r_mask};
      default: io_readdata = {5'b0, r_mask, dma_req, r_tc};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_base_addr    <= 16'h0000;
      r_cur_addr     <= 16'h0000;
      r_base_cnt     <= 16'h0000;
      r_cur_cnt      <= 16'h0000;
      r_page         <= 8'h00;
      r_mode         <= 3'b000;
      r_mask         <= 1'b1;
      r_tc           <= 1'b0;
      r_mem_address  <= 24'h000000;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_dma_ack      <= 1'b0;
      r_dma_terminal <= 1'b0;
      r_dma_readdata <= 8'h00;
    end else begin
      // Clear first so a terminal count in the same cycle still sets tc.
      if (io_read && io_address == 3'd7) r_tc <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (dma_req && !r_mask) begin
            r_mem_address <= {r_page, r_cur_addr};
            if (r_mode[2]) begin
              r_mem_write <= 1'b1;
              r_state     <= S_WR;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= S_RD;
            end
          end
        end
        S_RD: begin
          if (!mem_waitrequest) begin
            r_mem_read <= 1'b0;
            r_state    <= S_RDW;
          end
        end
        S_RDW: begin
          if (mem_readdatavalid) begin
            r_dma_readdata <= mem_readdata;
            r_dma_ack      <= 1'b1;
            r_dma_terminal <= (r_cur_cnt == 16'h0000);
            r_state        <= S_ACK;
          end
        end
        S_WR: begin
          if (!mem_waitrequest) begin
            r_mem_write    <= 1'b0;
            r_dma_ack      <= 1'b1;
            r_dma_terminal <= (r_cur_cnt == 16'h0000);
            r_state        <= S_ACK;
          end
        end
        S_ACK: begin
          r_dma_ack      <= 1'b0;
          r_dma_terminal <= 1'b0;
          r_state        <= S_HOLD;
          if (r_dma_terminal && r_mode[0]) begin
            r_tc       <= 1'b1;
            r_cur_addr <= r_base_addr;
            r_cur_cnt  <= r_base_cnt;
          end else begin
            if (r_dma_terminal) begin
              r_tc   <= 1'b1;
              r_mask <= 1'b1;
            end
            r_cur_addr <= r_cur_addr + w_step;
            r_cur_cnt  <= r_cur_cnt - 16'h0001;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // CPU writes land last so they override a concurrent channel update.
      if (io_write) begin
        case (io_address)
          3'd0: begin r_base_addr[7:0]  <= io_writedata; r_cur_addr[7:0]  <= io_writedata; end
          3'd1: begin r_base_addr[15:8] <= io_writedata; r_cur_addr[15:8] <= io_writedata; end
          3'd2: r_page <= io_writedata;
          3'd3: begin r_base_cnt[7:0]   <= io_writedata; r_cur_cnt[7:0]   <= io_writedata; end
          3'd4: begin r_base_cnt[15:8]  <= io_writedata; r_cur_cnt[15:8]  <= io_writedata; end
          3'd5: r_mode <= io_writedata[2:0];
          3'd6: r_mask <= io_writedata[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_dma_channel.sv
// Directed bench for sound_dma_channel: register window, playback, autoinit,
// wrap, record with stalls, masking and reset during a read.
module tb_sound_dma_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  io_address;
  logic        io_read, io_write;
  logic [7:0]  io_readdata, io_writedata;
  logic        dma_req, dma_ack, dma_terminal;
  logic [7:0]  dma_readdata, dma_writedata;
  logic [23:0] mem_address;
  logic        mem_read, mem_write;
  logic [7:0]  mem_writedata;
  logic        mem_waitrequest = 1'b0;
  logic        mem_readdatavalid = 1'b0;
  logic [7:0]  mem_readdata = 8'h00;

  sound_dma_channel dut (
    .clk(clk), .rst(rst),
    .io_address(io_address), .io_read(io_read), .io_readdata(io_readdata),
    .io_write(io_write), .io_writedata(io_writedata),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_terminal(dma_terminal),
    .dma_readdata(dma_readdata), .dma_writedata(dma_writedata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // memory slave and bus monitor state (written only by the monitor)
  logic [23:0] rd_log [0:63];
  logic [7:0]  ack_data [0:63];
  logic [23:0] rd_pend = 24'h0, wr_addr = 24'h0;
  int n_rd = 0, n_wr = 0, n_ack = 0, n_term = 0, term_at = 0;
  int wr_cyc = 0, wr_bad = 0, ovl = 0, rd_wait = 0, stall_done = 0;
  // configuration (written only by the stimulus)
  int rd_lat = 1, stall_tgt = 0;

  function automatic logic [7:0] mdata(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  always @(negedge clk) begin
    if (rd_wait > 0) begin
      rd_wait = rd_wait - 1;
      mem_readdatavalid = (rd_wait == 0);
      mem_readdata = mdata(rd_pend);
    end else begin
      mem_readdatavalid = 1'b0;
    end
    mem_waitrequest = 1'b0;
    if ((mem_read || mem_write) && stall_done < stall_tgt) begin
      mem_waitrequest = 1'b1;
      stall_done = stall_done + 1;
    end
    if (mem_read && !mem_waitrequest) begin
      if (n_rd < 64) rd_log[n_rd] = mem_address;
      n_rd = n_rd + 1;
      rd_pend = mem_address;
      rd_wait = rd_lat;
    end
    if (mem_write) begin
      wr_cyc = wr_cyc + 1;
      if (mem_writedata !== 8'hA5) wr_bad = wr_bad + 1;
      if (dma_ack) ovl = ovl + 1;
    end
    if (mem_write && !mem_waitrequest) begin
      n_wr = n_wr + 1;
      wr_addr = mem_address;
    end
    if (dma_ack) begin
      if (n_ack < 64) ack_data[n_ack] = dma_readdata;
      n_ack = n_ack + 1;
      if (dma_terminal) begin
        n_term = n_term + 1;
        term_at = n_ack;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic io_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    io_address = a; io_writedata = d; io_write = 1'b1;
    @(negedge clk); #1;
    io_write = 1'b0;
  endtask

  task automatic io_rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk); #1;
    io_address = a; io_read = 1'b1;
    #1 chk(tag, 32'(io_readdata), 32'(exp));
    @(negedge clk); #1;
    io_read = 1'b0;
  endtask

  task automatic wait_acks(input string tag, input int n, input int budget);
    int k = 0;
    while (n_ack < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 32'(n_ack >= n), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int b_rd, b_ack;

  initial begin
    rst = 1'b1; io_address = 3'd0; io_read = 1'b0; io_write = 1'b0;
    io_writedata = 8'h00; dma_req = 1'b0; dma_writedata = 8'h00;
    idle(3);
    rst = 1'b0;

    // reset state
    chk("rst_ack", 32'(dma_ack), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    io_rd("rst_addr0", 3'd0, 8'h00);
    io_rd("rst_cnt0", 3'd3, 8'h00);
    io_rd("rst_mask", 3'd6, 8'h01);
    io_rd("rst_status", 3'd7, 8'h04);

    // playback, 3-byte block
    io_wr(3'd0, 8'h00); io_wr(3'd1, 8'h10); io_wr(3'd2, 8'h02);
    io_wr(3'd3, 8'h02); io_wr(3'd4, 8'h00); io_wr(3'd5, 8'h00); io_wr(3'd6, 8'h00);
    b_rd = n_rd; b_ack = n_ack;
    dma_req = 1'b1;
    wait_acks("pb_timeout", b_ack + 3, 200);
    dma_req = 1'b0;
    idle(10);
    chk("pb_nrd", 32'(n_rd - b_rd), 32'd3);
    chk("pb_a0", 32'(rd_log[b_rd]), 32'h021000);
    chk("pb_a1", 32'(rd_log[b_rd+1]), 32'h021001);
    chk("pb_a2", 32'(rd_log[b_rd+2]), 32'h021002);
    chk("pb_d0", 32'(ack_data[b_ack]), 32'(mdata(24'h021000)));
    chk("pb_d2", 32'(ack_data[b_ack+2]), 32'(mdata(24'h021002)));
    chk("pb_nack", 32'(n_ack - b_ack), 32'd3);
    chk("pb_term_at", 32'(term_at - b_ack), 32'd3);
    io_rd("pb_mask", 3'd6, 8'h01);
    io_rd("pb_status", 3'd7, 8'h05);
    io_rd("pb_tc_cleared", 3'd7, 8'h04);
    io_rd("pb_addr_lo", 3'd0, 8'h03);

    // autoinit, decrement
    io_wr(3'd0, 8'h01); io_wr(3'd1, 8'h00); io_wr(3'd3, 8'h01); io_wr(3'd4, 8'h00);
    io_wr(3'd5, 8'h03); io_wr(3'd6, 8'h00);
    b_rd = n_rd; b_ack = n_ack;
    dma_req = 1'b1;
    wait_acks("ai_timeout", b_ack + 2, 200);
    dma_req = 1'b0;
    idle(10);
    chk("ai_a0", 32'(rd_log[b_rd]), 32'h020001);
    chk("ai_a1", 32'(rd_log[b_rd+1]), 32'h020000);
    chk("ai_term_at", 32'(term_at - b_ack), 32'd2);
    io_rd("ai_addr_lo", 3'd0, 8'h01);
    io_rd("ai_addr_hi", 3'd1, 8'h00);
    io_rd("ai_cnt_lo", 3'd3, 8'h01);
    io_rd("ai_cnt_hi", 3'd4, 8'h00);
    io_rd("ai_mask", 3'd6, 8'h00);
    io_rd("ai_status", 3'd7, 8'h01);
    b_rd = n_rd; b_ack = n_ack;
    dma_req = 1'b1;
    wait_acks("ai3_timeout", b_ack + 1, 100);
    dma_req = 1'b0;
    idle(10);
    chk("ai3_nrd", 32'(n_rd - b_rd), 32'd1);
    chk("ai3_a", 32'(rd_log[b_rd]), 32'h020001);

    // 16-bit address wrap, page fixed
    io_wr(3'd5, 8'h00); io_wr(3'd0, 8'hFF); io_wr(3'd1, 8'hFF); io_wr(3'd2, 8'h05);
    io_wr(3'd3, 8'h01); io_wr(3'd4, 8'h00); io_wr(3'd6, 8'h00);
    b_rd = n_rd; b_ack = n_ack;
    dma_req = 1'b1;
    wait_acks("wr_timeout", b_ack + 2, 200);
    dma_req = 1'b0;
    idle(10);
    chk("wrap_a0", 32'(rd_log[b_rd]), 32'h05FFFF);
    chk("wrap_a1", 32'(rd_log[b_rd+1]), 32'h050000);
    io_rd("wrap_page", 3'd2, 8'h05);

    // record with three stall cycles, single-byte block
    io_wr(3'd5, 8'h04); io_wr(3'd0, 8'h34); io_wr(3'd1, 8'h12);
    io_wr(3'd3, 8'h00); io_wr(3'd4, 8'h00); io_wr(3'd6, 8'h00);
    dma_writedata = 8'hA5;
    stall_tgt = stall_done + 3;
    b_rd = n_rd; b_ack = n_ack;
    dma_req = 1'b1;
    wait_acks("rec_timeout", b_ack + 1, 100);
    dma_req = 1'b0;
    idle(10);
    chk("rec_wr_cycles", 32'(wr_cyc), 32'd4);
    chk("rec_wr_data", 32'(wr_bad), 32'd0);
    chk("rec_nwr", 32'(n_wr), 32'd1);
    chk("rec_wr_addr", 32'(wr_addr), 32'h051234);
    chk("rec_nack", 32'(n_ack - b_ack), 32'd1);
    chk("rec_ack_stall", 32'(ovl), 32'd0);
    chk("rec_nrd", 32'(n_rd - b_rd), 32'd0);

    // masked request, then unmask and drop req during the ack
    io_wr(3'd5, 8'h00); io_wr(3'd3, 8'h05);
    b_rd = n_rd; b_ack = n_ack;
    dma_req = 1'b1;
    idle(10);
    chk("mask_nrd", 32'(n_rd - b_rd), 32'd0);
    chk("mask_nack", 32'(n_ack - b_ack), 32'd0);
    io_wr(3'd6, 8'h00);
    wait_acks("unmask_timeout", b_ack + 1, 100);
    dma_req = 1'b0;
    idle(10);
    chk("unmask_nack", 32'(n_ack - b_ack), 32'd1);
    chk("unmask_nrd", 32'(n_rd - b_rd), 32'd1);

    // reset while waiting for read data
    rd_lat = 6;
    b_rd = n_rd; b_ack = n_ack;
    dma_req = 1'b1;
    begin
      int k = 0;
      while (n_rd == b_rd && k < 50) begin
        @(negedge clk); #1;
        k++;
      end
    end
    chk("rr_read_issued", 32'(n_rd - b_rd), 32'd1);
    @(negedge clk); #1;
    rst = 1'b1; dma_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("rr_mem_read", 32'(mem_read), 32'd0);
    chk("rr_ack", 32'(dma_ack), 32'd0);
    chk("rr_mem_addr", 32'(mem_address), 32'd0);
    io_rd("rr_addr_hi", 3'd1, 8'h00);
    io_rd("rr_page", 3'd2, 8'h00);
    io_rd("rr_cnt_lo", 3'd3, 8'h00);
    io_rd("rr_mode", 3'd5, 8'h00);
    io_rd("rr_mask", 3'd6, 8'h01);
    idle(12);
    chk("rr_no_ack", 32'(n_ack - b_ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
